// File: rtl/chaos_map_seq.sv
// Sequencer for the Q1.15 quadratic-map core: load, warm-up, stream samples over
// valid/ready, and reseed the core automatically when the orbit collapses.
module chaos_map_seq #(
    parameter int MAP_LAT   = 3,
    parameter int WARMUP    = 64,
    parameter int STUCK_LIM = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic [15:0] seed,
    input  logic [15:0] r_cfg,
    output logic        map_load,
    output logic [15:0] map_seed,
    output logic [15:0] map_r,
    output logic        map_step,
    input  logic [15:0] map_x,
    output logic        out_valid,
    output logic [15:0] out_data,
    input  logic        out_ready,
    output logic        busy,
    output logic [7:0]  reseed_cnt
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WARM, S_RUN, S_HOLD} state_t;

    localparam logic [3:0] LAT_C  = 4'(MAP_LAT);
    localparam logic [9:0] WARM_C = 10'(WARMUP);
    localparam logic [3:0] LIM_C  = 4'(STUCK_LIM);

    state_t      state_q, state_d;
    logic [15:0] cur_seed_q, cur_seed_d;
    logic [15:0] map_r_q, map_r_d;
    logic [15:0] prev_x_q, prev_x_d;
    logic [15:0] out_data_q, out_data_d;
    logic        out_valid_q, out_valid_d;
    logic [3:0]  stuck_q, stuck_d;
    logic [9:0]  iter_q, iter_d;
    logic [3:0]  lat_q, lat_d;
    logic [7:0]  reseed_q, reseed_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cur_seed_q  <= '0;
            map_r_q     <= '0;
            prev_x_q    <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            stuck_q     <= '0;
            iter_q      <= '0;
            lat_q       <= '0;
            reseed_q    <= '0;
        end else begin
            state_q     <= state_d;
            cur_seed_q  <= cur_seed_d;
            map_r_q     <= map_r_d;
            prev_x_q    <= prev_x_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            stuck_q     <= stuck_d;
            iter_q      <= iter_d;
            lat_q       <= lat_d;
            reseed_q    <= reseed_d;
        end
    end

    logic [15:0] lfsr_nx;
    logic [3:0]  stuck_nx;
    logic        is_stuck;

    always_comb begin
        state_d     = state_q;
        cur_seed_d  = cur_seed_q;
        map_r_d     = map_r_q;
        prev_x_d    = prev_x_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        stuck_d     = stuck_q;
        iter_d      = iter_q;
        lat_d       = lat_q;
        reseed_d    = reseed_q;
        is_stuck    = 1'b0;
        stuck_nx    = '0;

        // Reseed value: one LFSR shift, never allowed to land on the all-zero lock-up state.
        lfsr_nx = {cur_seed_q[14:0], cur_seed_q[15] ^ cur_seed_q[13] ^ cur_seed_q[12] ^ cur_seed_q[10]};
        if (lfsr_nx == 16'h0000) lfsr_nx = 16'h0001;

        case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    cur_seed_d = seed;
                    map_r_d    = r_cfg;
                    reseed_d   = '0;
                    state_d    = S_LOAD;
                end
            end
            S_LOAD: begin
                prev_x_d = cur_seed_q;
                stuck_d  = '0;
                iter_d   = '0;
                lat_d    = '0;
                state_d  = S_WARM;
            end
            S_WARM, S_RUN: begin
                // lat_q==0 is the step cycle; lat_q==MAP_LAT is the capture cycle.
                if (lat_q == LAT_C) begin
                    lat_d    = '0;
                    is_stuck = (map_x == prev_x_q) || (map_x == 16'h0000);
                    stuck_nx = is_stuck ? stuck_q + 4'd1 : 4'd0;
                    stuck_d  = stuck_nx;
                    prev_x_d = map_x;
                    if (stuck_nx == LIM_C) begin
                        cur_seed_d = lfsr_nx;
                        if (reseed_q != 8'hFF) reseed_d = reseed_q + 8'd1;
                        state_d = S_LOAD;
                    end else if (state_q == S_WARM) begin
                        iter_d = iter_q + 10'd1;
                        if ((iter_q + 10'd1) == WARM_C) state_d = S_RUN;
                    end else begin
                        out_data_d  = map_x;
                        out_valid_d = 1'b1;
                        state_d     = S_HOLD;
                    end
                end else begin
                    lat_d = lat_q + 4'd1;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (stop) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
        end
    end

    always_comb begin
        map_load   = (state_q == S_LOAD);
        map_step   = ((state_q == S_WARM) || (state_q == S_RUN)) && (lat_q == 4'd0);
        busy       = (state_q != S_IDLE);
        map_seed   = cur_seed_q;
        map_r      = map_r_q;
        out_valid  = out_valid_q;
        out_data   = out_data_q;
        reseed_cnt = reseed_q;
    end

endmodule

// File: tb/tb_chaos_map_seq.sv
// Directed bench for chaos_map_seq with a stand-in core (affine x+r, constant, or zero)
// answering exactly MAP_LAT cycles after each step.
module tb_chaos_map_seq;
    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        reset, start, stop, out_ready;
    logic [15:0] seed, r_cfg, map_x, map_seed, map_r, out_data;
    logic        map_load, map_step, out_valid, busy;
    logic [7:0]  reseed_cnt;

    int n_chk = 0;
    int n_err = 0;

    int          mode = 0;
    logic [15:0] core_x = 16'h0000;
    int          core_cnt = 0;

    chaos_map_seq #(.MAP_LAT(LAT), .WARMUP(4), .STUCK_LIM(4)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .seed(seed), .r_cfg(r_cfg),
        .map_load(map_load), .map_seed(map_seed), .map_r(map_r),
        .map_step(map_step), .map_x(map_x),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .busy(busy), .reseed_cnt(reseed_cnt)
    );

    always #5 clk = ~clk;

    // Stand-in core: result is visible only in the exact capture cycle, garbage otherwise.
    always @(posedge clk) begin
        if (map_load) begin
            core_x   <= map_seed;
            core_cnt <= 0;
        end else if (map_step) begin
            core_x   <= (mode == 0) ? core_x + map_r : (mode == 1) ? 16'h2000 : 16'h0000;
            core_cnt <= 1;
        end else begin
            core_cnt <= (core_cnt != 0 && core_cnt < LAT) ? core_cnt + 1 : 0;
        end
    end
    assign map_x = (core_cnt == LAT) ? core_x : 16'hA5A5;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Pulse start so it is sampled at the next edge; returns in cycle 1.
    task automatic go(input logic [15:0] s, input logic [15:0] r);
        seed  = s;
        r_cfg = r;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_load"},   map_load,   0);
        chk({tag, "_step"},   map_step,   0);
        chk({tag, "_valid"},  out_valid,  0);
        chk({tag, "_busy"},   busy,       0);
        chk({tag, "_seed"},   map_seed,   0);
        chk({tag, "_r"},      map_r,      0);
        chk({tag, "_data"},   out_data,   0);
        chk({tag, "_reseed"}, reseed_cnt, 0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; out_ready = 1'b0;
        seed = 16'h0; r_cfg = 16'h0;
        #12;
        chk_reset_vals("rst");
        tick();
        reset = 1'b0;
        tick();

        // Start and first sample: affine core gives 8000,F000,6000,D000,4000.
        go(16'h1000, 16'h7000);
        chk("c1_load", map_load, 1);
        chk("c1_seed", map_seed, 16'h1000);
        chk("c1_busy", busy, 1);
        for (int c = 2; c <= 22; c++) begin
            tick();
            chk($sformatf("step_c%0d", c), map_step, (c % 4 == 2) && (c <= 18));
            chk($sformatf("valid_c%0d", c), out_valid, c == 22);
        end
        chk("first_data", out_data, 16'h4000);

        // Backpressure through cycle 32.
        for (int c = 23; c <= 32; c++) begin
            tick();
            chk($sformatf("bp_valid_c%0d", c), out_valid, 1);
            chk($sformatf("bp_data_c%0d", c), out_data, 16'h4000);
            chk($sformatf("bp_step_c%0d", c), map_step, 0);
        end
        out_ready = 1'b1;
        tick();
        chk("hs_valid", out_valid, 0);
        chk("hs_step", map_step, 1);
        repeat (4) tick();
        chk("s2_valid", out_valid, 1);
        chk("s2_data", out_data, 16'hB000);
        tick();
        chk("s2_hs_step", map_step, 1);
        repeat (4) tick();
        chk("s3_valid", out_valid, 1);
        chk("s3_data", out_data, 16'h2000);

        // Stop in HOLD.
        out_ready = 1'b0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_valid", out_valid, 0);
        chk("stop_busy", busy, 0);
        chk("stop_step", map_step, 0);

        // Stop and start together in IDLE.
        seed = 16'h3333; r_cfg = 16'h1111;
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        chk("ss_busy", busy, 0);
        chk("ss_load", map_load, 0);
        chk("ss_r", map_r, 16'h7000);
        tick();
        chk("ss_busy2", busy, 0);

        // Start while in WARM is ignored.
        go(16'h1000, 16'h7000);
        repeat (3) tick();
        r_cfg = 16'h1234;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("warm_start_r", map_r, 16'h7000);
        chk("warm_start_load", map_load, 0);
        chk("warm_start_busy", busy, 1);
        repeat (17) tick();
        chk("ws_valid", out_valid, 1);
        chk("ws_data", out_data, 16'h4000);

        // Asynchronous reset while a sample is pending.
        #2;
        reset = 1'b1;
        #1;
        chk_reset_vals("arst");
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick();
        go(16'h2000, 16'h7000);
        chk("post_rst_load", map_load, 1);
        chk("post_rst_seed", map_seed, 16'h2000);
        stop = 1'b1;
        tick();
        stop = 1'b0;

        // Constant 2000 core: 5th capture (end of cycle 21) reseeds.
        mode = 1;
        go(16'h1000, 16'h0000);
        for (int c = 2; c <= 21; c++) begin
            tick();
            chk($sformatf("k_valid_c%0d", c), out_valid, 0);
            chk($sformatf("k_load_c%0d", c), map_load, 0);
        end
        tick();
        chk("k_load", map_load, 1);
        chk("k_seed", map_seed, 16'h2001);
        chk("k_reseed", reseed_cnt, 1);
        chk("k_valid", out_valid, 0);
        stop = 1'b1;
        tick();
        stop = 1'b0;

        // Zero core: 4th capture (end of cycle 17) reseeds.
        mode = 2;
        go(16'h1000, 16'h0000);
        for (int c = 2; c <= 17; c++) begin
            tick();
            chk($sformatf("z_load_c%0d", c), map_load, 0);
        end
        tick();
        chk("z_load", map_load, 1);
        chk("z_seed", map_seed, 16'h2001);
        chk("z_reseed", reseed_cnt, 1);
        chk("z_step", map_step, 0);

        // Each further reseed takes 17 cycles; run well past 255.
        repeat (300 * 17) tick();
        chk("sat_reseed", reseed_cnt, 8'hFF);
        chk("sat_busy", busy, 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("end_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
